// File: rtl/draw_score_pkg.sv
// rtl/draw_score_pkg.sv - shared constants, timing bundle and flash helper for draw_score
package draw_score_pkg;

    localparam int GLYPH_W = 8;
    localparam int GLYPH_H = 8;
    localparam int ROM_AW  = 7;
    localparam logic [11:0] BLANK_RGB = 12'h0_0_0;

    typedef struct packed {
        logic [11:0] hcount;
        logic        hsync;
        logic        hblnk;
        logic [11:0] vcount;
        logic        vsync;
        logic        vblnk;
    } vga_timing_t;

    // A change reloads the blink window; otherwise it runs down to zero and stays.
    function automatic logic [7:0] next_flash(input logic changed, input logic [7:0] cnt,
                                              input logic [7:0] reload);
        if (changed)
            return reload;
        else if (cnt != 8'd0)
            return cnt - 8'd1;
        else
            return cnt;
    endfunction

endpackage

// File: rtl/score_font_rom.sv
// rtl/score_font_rom.sv - 16 hex glyphs x 8 rows, registered read, MSB is leftmost pixel
module score_font_rom
    import draw_score_pkg::*;
(
    input  logic              clk,
    input  logic [ROM_AW-1:0] address,
    output logic [7:0]        data
);

    logic [63:0] glyph;

    always_comb begin
        glyph = '0;
        case (address[6:3])
            4'h0: glyph = 64'h3C666E7666663C00;
            4'h1: glyph = 64'h1838181818187E00;
            4'h2: glyph = 64'h3C66060C30607E00;
            4'h3: glyph = 64'h3C66061C06663C00;
            4'h4: glyph = 64'h0C1C3C6C7E0C0C00;
            4'h5: glyph = 64'h7E607C0606663C00;
            4'h6: glyph = 64'h3C607C6666663C00;
            4'h7: glyph = 64'h7E060C1830303000;
            4'h8: glyph = 64'h3C66663C66663C00;
            4'h9: glyph = 64'h3C66663E060C3800;
            4'hA: glyph = 64'h183C66667E666600;
            4'hB: glyph = 64'h7C66667C66667C00;
            4'hC: glyph = 64'h3C66606060663C00;
            4'hD: glyph = 64'h786C6666666C7800;
            4'hE: glyph = 64'h7E60607860607E00;
            4'hF: glyph = 64'h7E60607860606000;
        endcase
    end

    // Row 0 lives in the top byte of the glyph word.
    always_ff @(posedge clk) begin
        data <= glyph[{~address[2:0], 3'b000} +: 8];
    end

endmodule

// File: rtl/draw_score.sv
// rtl/draw_score.sv - overlays both players' scores as scaled blinking hex glyphs on the VGA stream
module draw_score
    import draw_score_pkg::*;
#(
    parameter int          P1_XPOS      = 384,
    parameter int          P2_XPOS      = 608,
    parameter int          DIGIT_YPOS   = 16,
    parameter int          SCALE_LOG2   = 2,
    parameter logic [11:0] DIGIT_COLOR  = 12'hf_f_f,
    parameter int          FLASH_FRAMES = 64
) (
    input  logic        clk_in,
    input  logic        rst,
    input  logic [11:0] hcount_in,
    input  logic        hsync_in,
    input  logic        hblnk_in,
    input  logic [11:0] vcount_in,
    input  logic        vsync_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    input  logic [3:0]  player_1_score,
    input  logic [3:0]  player_2_score,
    output logic [11:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [11:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out
);

    localparam int BOX_W = GLYPH_W << SCALE_LOG2;
    localparam int BOX_H = GLYPH_H << SCALE_LOG2;
    localparam logic [11:0] X1_LO = 12'(P1_XPOS);
    localparam logic [11:0] X1_HI = 12'(P1_XPOS + BOX_W);
    localparam logic [11:0] X2_LO = 12'(P2_XPOS);
    localparam logic [11:0] X2_HI = 12'(P2_XPOS + BOX_W);
    localparam logic [11:0] Y_LO  = 12'(DIGIT_YPOS);
    localparam logic [11:0] Y_HI  = 12'(DIGIT_YPOS + BOX_H);
    localparam logic [7:0]  FLASH_RELOAD = 8'(FLASH_FRAMES);

    logic       vblnk_prev;
    logic       frame_tick;
    logic [3:0] shadow_p1, shadow_p2;
    logic [7:0] flash_cnt_1, flash_cnt_2;
    logic [7:0] frame_cnt;

    assign frame_tick = vblnk_in & ~vblnk_prev;

    // Scores are only sampled at the frame boundary so a digit never changes mid-scan.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            vblnk_prev  <= 1'b0;
            shadow_p1   <= '0;
            shadow_p2   <= '0;
            flash_cnt_1 <= '0;
            flash_cnt_2 <= '0;
            frame_cnt   <= '0;
        end else begin
            vblnk_prev <= vblnk_in;
            if (frame_tick) begin
                shadow_p1   <= player_1_score;
                shadow_p2   <= player_2_score;
                flash_cnt_1 <= next_flash(player_1_score != shadow_p1, flash_cnt_1, FLASH_RELOAD);
                flash_cnt_2 <= next_flash(player_2_score != shadow_p2, flash_cnt_2, FLASH_RELOAD);
                frame_cnt   <= frame_cnt + 8'd1;
            end
        end
    end

    logic              in_y, in_box1, in_box2;
    logic [11:0]       dx, dy;
    logic [2:0]        row, col;
    logic [3:0]        digit;
    logic              visible1, visible2, visible;
    logic [ROM_AW-1:0] rom_addr;
    logic [7:0]        rom_data;

    always_comb begin
        in_y     = (vcount_in >= Y_LO) && (vcount_in < Y_HI);
        in_box1  = in_y && (hcount_in >= X1_LO) && (hcount_in < X1_HI);
        in_box2  = in_y && !in_box1 && (hcount_in >= X2_LO) && (hcount_in < X2_HI);
        dx       = in_box1 ? (hcount_in - X1_LO) : in_box2 ? (hcount_in - X2_LO) : 12'd0;
        dy       = (in_box1 || in_box2) ? (vcount_in - Y_LO) : 12'd0;
        row      = 3'(dy >> SCALE_LOG2);
        col      = 3'(dx >> SCALE_LOG2);
        visible1 = (flash_cnt_1 == 8'd0) || !frame_cnt[3];
        visible2 = (flash_cnt_2 == 8'd0) || !frame_cnt[3];
        digit    = in_box2 ? shadow_p2 : shadow_p1;
        visible  = in_box2 ? visible2 : visible1;
        rom_addr = {digit, row};
    end

    score_font_rom u_font_rom (
        .clk     (clk_in),
        .address (rom_addr),
        .data    (rom_data)
    );

    vga_timing_t s1_timing;
    logic [11:0] s1_rgb;
    logic        s1_in_box;
    logic [2:0]  s1_col;
    logic        s1_visible;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            s1_timing  <= '0;
            s1_rgb     <= '0;
            s1_in_box  <= 1'b0;
            s1_col     <= '0;
            s1_visible <= 1'b0;
        end else begin
            s1_timing.hcount <= hcount_in;
            s1_timing.hsync  <= hsync_in;
            s1_timing.hblnk  <= hblnk_in;
            s1_timing.vcount <= vcount_in;
            s1_timing.vsync  <= vsync_in;
            s1_timing.vblnk  <= vblnk_in;
            s1_rgb           <= rgb_in;
            s1_in_box        <= in_box1 || in_box2;
            s1_col           <= col;
            s1_visible       <= visible;
        end
    end

    logic lit;
    assign lit = s1_in_box & s1_visible & rom_data[~s1_col];

    always_ff @(posedge clk_in) begin
        if (rst) begin
            hcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= s1_timing.hcount;
            hsync_out  <= s1_timing.hsync;
            hblnk_out  <= s1_timing.hblnk;
            vcount_out <= s1_timing.vcount;
            vsync_out  <= s1_timing.vsync;
            vblnk_out  <= s1_timing.vblnk;
            if (s1_timing.hblnk || s1_timing.vblnk)
                rgb_out <= BLANK_RGB;
            else if (lit)
                rgb_out <= DIGIT_COLOR;
            else
                rgb_out <= s1_rgb;
        end
    end

endmodule

// File: tb/tb_draw_score.sv
// tb/tb_draw_score.sv - randomized directed bench for draw_score against a frame-level reference model
module tb_draw_score;

    localparam int P1 = 384;
    localparam int P2 = 608;
    localparam int Y0 = 16;
    localparam int BOX = 32;
    localparam int FLASH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] hcount_in, vcount_in, rgb_in;
    logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
    logic [3:0]  sc1, sc2;
    logic [11:0] hcount_out, vcount_out, rgb_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;

    always #5 clk = ~clk;

    draw_score dut (
        .clk_in         (clk),
        .rst            (rst),
        .hcount_in      (hcount_in),
        .hsync_in       (hsync_in),
        .hblnk_in       (hblnk_in),
        .vcount_in      (vcount_in),
        .vsync_in       (vsync_in),
        .vblnk_in       (vblnk_in),
        .rgb_in         (rgb_in),
        .player_1_score (sc1),
        .player_2_score (sc2),
        .hcount_out     (hcount_out),
        .hsync_out      (hsync_out),
        .hblnk_out      (hblnk_out),
        .vcount_out     (vcount_out),
        .vsync_out      (vsync_out),
        .vblnk_out      (vblnk_out),
        .rgb_out        (rgb_out)
    );

    logic [63:0] font [16];
    int          shadow [2];
    int          flash [2];
    int          frame_cnt;
    bit          prev_v;
    logic [39:0] e_prev;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [11:0] exp_rgb(input int h, input int v, input logic hb,
                                            input logic vb, input logic [11:0] rgb);
        int x0, px, py;
        bit vis;
        if (hb || vb) return 12'h000;
        for (int p = 0; p < 2; p++) begin
            x0 = (p == 0) ? P1 : P2;
            if (h >= x0 && h < x0 + BOX && v >= Y0 && v < Y0 + BOX) begin
                px  = (h - x0) / 4;
                py  = (v - Y0) / 4;
                vis = (flash[p] == 0) || (((frame_cnt / 8) % 2) == 0);
                if (vis && font[shadow[p]][63 - 8 * py - px]) return 12'hfff;
                return rgb;
            end
        end
        return rgb;
    endfunction

    task automatic drive(input logic r, input int h, input int v, input logic hs, input logic hb,
                         input logic vs, input logic vb, input logic [11:0] rgb);
        logic [39:0] e_new, expected, observed;
        int live;
        rst = r; hcount_in = 12'(h); vcount_in = 12'(v); hsync_in = hs; hblnk_in = hb;
        vsync_in = vs; vblnk_in = vb; rgb_in = rgb;
        e_new = r ? 40'd0 : {12'(h), hs, hb, 12'(v), vs, vb, exp_rgb(h, v, hb, vb, rgb)};
        if (r) begin
            shadow[0] = 0; shadow[1] = 0; flash[0] = 0; flash[1] = 0; frame_cnt = 0;
        end else if (vb && !prev_v) begin
            for (int p = 0; p < 2; p++) begin
                live = (p == 0) ? int'(sc1) : int'(sc2);
                if (live != shadow[p]) flash[p] = FLASH;
                else if (flash[p] > 0) flash[p] = flash[p] - 1;
                shadow[p] = live;
            end
            frame_cnt = (frame_cnt + 1) % 256;
        end
        prev_v = r ? 1'b0 : vb;
        @(posedge clk);
        #1;
        expected = r ? 40'd0 : e_prev;
        e_prev   = e_new;
        observed = {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out};
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL out h=%0d v=%0d obs=%h exp=%h", expected[39:28], expected[25:14], observed, expected);
        end
    endtask

    task automatic pix(input int h, input int v, input logic hb);
        drive(1'b0, h, v, 1'($urandom % 2), hb, 1'($urandom % 2), 1'b0, 12'($urandom_range(1, 4095)));
    endtask

    task automatic vblank(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, $urandom_range(0, 1343), $urandom_range(768, 805), 1'b0, 1'b1, 1'b0, 1'b1,
                  12'($urandom_range(1, 4095)));
    endtask

    task automatic sparse_frame();
        int bx[9] = '{P1 - 1, P1, P1 + 31, P1 + 32, P1, P1, P2 - 1, P2 + 32, P2 + 31};
        int by[9] = '{Y0, Y0, Y0 + 31, Y0, Y0 - 1, Y0 + 32, Y0 + 5, Y0 + 5, Y0};
        vblank(2);
        for (int i = 0; i < 9; i++) pix(bx[i], by[i], 1'b0);
        for (int i = 0; i < 12; i++) pix(P1 + $urandom_range(0, 31), Y0 + $urandom_range(0, 31), 1'b0);
        for (int i = 0; i < 12; i++) pix(P2 + $urandom_range(0, 31), Y0 + $urandom_range(0, 31), 1'b0);
        pix(P1 + $urandom_range(0, 31), Y0 + $urandom_range(0, 31), 1'b1);
    endtask

    task automatic scan_frame(input int change_row, input logic [3:0] new_score);
        vblank(2);
        for (int v = Y0 - 1; v <= Y0 + BOX; v++) begin
            if (v == change_row) sc1 = new_score;
            for (int h = P1 - 1; h <= P1 + BOX; h++) pix(h, v, 1'b0);
            for (int h = P2 - 1; h <= P2 + BOX; h++) pix(h, v, 1'b0);
        end
    endtask

    initial begin
        font = '{64'h3C666E7666663C00, 64'h1838181818187E00, 64'h3C66060C30607E00, 64'h3C66061C06663C00,
                 64'h0C1C3C6C7E0C0C00, 64'h7E607C0606663C00, 64'h3C607C6666663C00, 64'h7E060C1830303000,
                 64'h3C66663C66663C00, 64'h3C66663E060C3800, 64'h183C66667E666600, 64'h7C66667C66667C00,
                 64'h3C66606060663C00, 64'h786C6666666C7800, 64'h7E60607860607E00, 64'h7E60607860606000};
        e_prev = '0; prev_v = 1'b0; sc1 = 4'd0; sc2 = 4'd0;
        shadow[0] = 0; shadow[1] = 0; flash[0] = 0; flash[1] = 0; frame_cnt = 0;

        for (int i = 0; i < 4; i++)
            drive(1'b1, $urandom_range(0, 1343), $urandom_range(0, 805), 1'b1, 1'b1, 1'b1, 1'b1, 12'habc);
        for (int i = 0; i < 40; i++)
            drive(1'b0, $urandom_range(0, 1343), $urandom_range(0, 805), 1'($urandom % 2),
                  1'($urandom % 2), 1'($urandom % 2), 1'b0, 12'($urandom_range(0, 4095)));

        sc1 = 4'd3; sc2 = 4'd7;
        scan_frame(-1, 4'd0);

        sc1 = 4'd1;
        scan_frame(20, 4'd2);
        scan_frame(-1, 4'd0);

        sc2 = 4'd5;
        for (int f = 0; f < 80; f++) sparse_frame();

        sc1 = 4'd9; sc2 = 4'd10;
        for (int f = 0; f < 10; f++) sparse_frame();
        sc1 = 4'd4;
        for (int f = 0; f < 75; f++) sparse_frame();

        sc1 = 4'hC;
        sparse_frame();
        for (int f = 0; f < 20 && ((frame_cnt / 8) % 2) == 1; f++) sparse_frame();
        scan_frame(-1, 4'd0);

        for (int i = 0; i < 30; i++) pix(P2 + $urandom_range(0, 31), Y0 + $urandom_range(0, 31), 1'b0);
        for (int i = 0; i < 3; i++)
            drive(1'b1, P1 + 4, Y0 + 4, 1'b1, 1'b0, 1'b1, 1'b0, 12'h123);
        sc1 = 4'd0; sc2 = 4'd6;
        for (int i = 0; i < 10; i++) pix(P1 + $urandom_range(0, 31), Y0 + $urandom_range(0, 31), 1'b0);
        for (int f = 0; f < 4; f++) sparse_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
